// File: rtl/mc_ctrl_if.sv
// Control/status bundle between the multicycle sequencer and the MIPS datapath.
// master = sequencer (drives mux selects and strobes), slave = datapath side.
interface mc_ctrl_if;
  logic [31:0] instr;
  logic        mem_ready;
  logic        alu_zero;
  logic        alu_overflow;
  logic [3:0]  alu_ctrl;
  logic        alu_srca_sel;
  logic [1:0]  alu_srcb_sel;
  logic        imm_zext;
  logic        iord;
  logic        mem_read;
  logic        mem_write;
  logic        ir_write;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic        reg_write;
  logic        reg_dst;
  logic        mem_to_reg;
  logic        exc;
  logic [3:0]  state;

  modport master (
    input  instr, mem_ready, alu_zero, alu_overflow,
    output alu_ctrl, alu_srca_sel, alu_srcb_sel, imm_zext, iord, mem_read,
           mem_write, ir_write, pc_write, pc_src, reg_write, reg_dst,
           mem_to_reg, exc, state
  );

  modport slave (
    output instr, mem_ready, alu_zero, alu_overflow,
    input  alu_ctrl, alu_srca_sel, alu_srcb_sel, imm_zext, iord, mem_read,
           mem_write, ir_write, pc_write, pc_src, reg_write, reg_dst,
           mem_to_reg, exc, state
  );
endinterface

// File: rtl/mc_ctrl.sv
// Multicycle MIPS sequencer: Moore controls from state+IR, 3..5 cycles per instruction.
// Memory states stall on mem_ready; a stall of MEM_TIMEOUT cycles diverts to the exception state.
module mc_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input logic       clk,
  input logic       rst_n,
  mc_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_EXEC    = 4'd2,
    S_WB_ALU  = 4'd3,
    S_MEM_RD  = 4'd4,
    S_WB_MEM  = 4'd5,
    S_MEM_WR  = 4'd6,
    S_BR_CMP  = 4'd7,
    S_BR_TGT  = 4'd8,
    S_BR_TAKE = 4'd9,
    S_JUMP    = 4'd10,
    S_EXC     = 4'd11
  } state_t;

  typedef enum logic [2:0] {
    K_ILL, K_ALU, K_LW, K_SW, K_BEQ, K_BNE, K_J
  } kind_t;

  typedef struct packed {
    logic [3:0] state;
    logic [3:0] alu_ctrl;
    logic       alu_srca_sel;
    logic [1:0] alu_srcb_sel;
    logic       imm_zext;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       exc;
  } ctl_t;

  state_t     state, state_n;
  logic [7:0] tmo_cnt;
  logic       eq;
  logic       waiting, tmo_hit;
  logic [5:0] op, funct;
  kind_t      kind;
  logic [3:0] dec_alu;
  logic [1:0] dec_srcb;
  logic       dec_zext, dec_rtype, dec_ovf;
  ctl_t       ctl;
  logic       unused_instr_bits;

  assign op                = bus.instr[31:26];
  assign funct             = bus.instr[5:0];
  assign unused_instr_bits = ^bus.instr[25:6];

  always_comb begin
    kind      = K_ILL;
    dec_alu   = 4'b0000;
    dec_srcb  = 2'd0;
    dec_zext  = 1'b0;
    dec_rtype = 1'b0;
    dec_ovf   = 1'b0;
    case (op)
      6'h00: begin
        kind      = K_ALU;
        dec_rtype = 1'b1;
        case (funct)
          6'h20: begin dec_alu = 4'b0010; dec_ovf = 1'b1; end
          6'h21: dec_alu = 4'b0011;
          6'h22: begin dec_alu = 4'b0100; dec_ovf = 1'b1; end
          6'h23: dec_alu = 4'b0101;
          6'h24: dec_alu = 4'b0000;
          6'h25: dec_alu = 4'b0001;
          6'h26: dec_alu = 4'b1110;
          6'h27: dec_alu = 4'b1111;
          6'h2A: dec_alu = 4'b0110;
          6'h2B: dec_alu = 4'b0111;
          6'h00: dec_alu = 4'b1000;
          6'h02: dec_alu = 4'b1001;
          6'h04: dec_alu = 4'b1010;
          6'h06: dec_alu = 4'b1011;
          default: kind = K_ILL;
        endcase
      end
      6'h08: begin kind = K_ALU; dec_alu = 4'b0010; dec_srcb = 2'd2; dec_ovf = 1'b1; end
      6'h09: begin kind = K_ALU; dec_alu = 4'b0011; dec_srcb = 2'd2; end
      6'h0A: begin kind = K_ALU; dec_alu = 4'b0110; dec_srcb = 2'd2; end
      6'h0B: begin kind = K_ALU; dec_alu = 4'b0111; dec_srcb = 2'd2; end
      6'h0C: begin kind = K_ALU; dec_alu = 4'b0000; dec_srcb = 2'd2; dec_zext = 1'b1; end
      6'h0D: begin kind = K_ALU; dec_alu = 4'b0001; dec_srcb = 2'd2; dec_zext = 1'b1; end
      6'h0E: begin kind = K_ALU; dec_alu = 4'b1110; dec_srcb = 2'd2; dec_zext = 1'b1; end
      6'h0F: begin kind = K_ALU; dec_alu = 4'b1100; dec_srcb = 2'd2; end
      6'h23: begin kind = K_LW;  dec_alu = 4'b0010; dec_srcb = 2'd2; end
      6'h2B: begin kind = K_SW;  dec_alu = 4'b0010; dec_srcb = 2'd2; end
      6'h04: kind = K_BEQ;
      6'h05: kind = K_BNE;
      6'h02: kind = K_J;
      default: kind = K_ILL;
    endcase
  end

  // The stall that would bring the counter up to the limit is the last one allowed.
  assign waiting = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
  assign tmo_hit = waiting && !bus.mem_ready &&
                   (({1'b0, tmo_cnt} + 9'd1) == 9'(MEM_TIMEOUT));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_FETCH;
      tmo_cnt <= 8'd0;
      eq      <= 1'b0;
    end else begin
      state <= state_n;
      if (state_n != state)
        tmo_cnt <= 8'd0;
      else if (waiting && !bus.mem_ready)
        tmo_cnt <= tmo_cnt + 8'd1;
      if (state == S_BR_TGT)
        eq <= bus.alu_zero;
    end
  end

  always_comb begin
    state_n = state;
    ctl     = '0;
    case (state)
      S_FETCH: begin
        ctl.mem_read     = 1'b1;
        ctl.alu_srcb_sel = 2'd1;
        ctl.alu_ctrl     = 4'b0011;
        ctl.ir_write     = bus.mem_ready;
        if (bus.mem_ready) state_n = S_DECODE;
        else if (tmo_hit)  state_n = S_EXC;
      end
      S_DECODE: begin
        ctl.pc_write = 1'b1;
        case (kind)
          K_ALU, K_LW, K_SW: state_n = S_EXEC;
          K_BEQ, K_BNE:      state_n = S_BR_CMP;
          K_J:               state_n = S_JUMP;
          default:           state_n = S_EXC;
        endcase
      end
      S_EXEC: begin
        ctl.alu_srca_sel = 1'b1;
        ctl.alu_srcb_sel = dec_srcb;
        ctl.alu_ctrl     = dec_alu;
        ctl.imm_zext     = dec_zext;
        case (kind)
          K_ALU:   state_n = S_WB_ALU;
          K_LW:    state_n = S_MEM_RD;
          K_SW:    state_n = S_MEM_WR;
          default: state_n = S_FETCH;
        endcase
      end
      S_WB_ALU: begin
        ctl.reg_dst = dec_rtype;
        if (dec_ovf && bus.alu_overflow) begin
          state_n = S_EXC;
        end else begin
          ctl.reg_write = 1'b1;
          state_n       = S_FETCH;
        end
      end
      S_MEM_RD: begin
        ctl.iord     = 1'b1;
        ctl.mem_read = 1'b1;
        if (bus.mem_ready) state_n = S_WB_MEM;
        else if (tmo_hit)  state_n = S_EXC;
      end
      S_WB_MEM: begin
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = 1'b1;
        state_n        = S_FETCH;
      end
      S_MEM_WR: begin
        ctl.iord      = 1'b1;
        ctl.mem_write = 1'b1;
        if (bus.mem_ready) state_n = S_FETCH;
        else if (tmo_hit)  state_n = S_EXC;
      end
      S_BR_CMP: begin
        ctl.alu_srca_sel = 1'b1;
        ctl.alu_ctrl     = 4'b0100;
        state_n          = S_BR_TGT;
      end
      S_BR_TGT: begin
        ctl.alu_srcb_sel = 2'd3;
        ctl.alu_ctrl     = 4'b0011;
        state_n          = S_BR_TAKE;
      end
      S_BR_TAKE: begin
        ctl.pc_write = ((kind == K_BEQ) && eq) || ((kind == K_BNE) && !eq);
        state_n      = S_FETCH;
      end
      S_JUMP: begin
        ctl.pc_write = 1'b1;
        ctl.pc_src   = 2'd2;
        state_n      = S_FETCH;
      end
      S_EXC: begin
        ctl.exc      = 1'b1;
        ctl.pc_write = 1'b1;
        ctl.pc_src   = 2'd3;
        state_n      = S_FETCH;
      end
      default: state_n = S_FETCH;
    endcase
    ctl.state = state;
    // Reset silences every strobe in the cycle it is applied, even mid-access.
    if (!rst_n) ctl = '0;
  end

  assign bus.state        = ctl.state;
  assign bus.alu_ctrl     = ctl.alu_ctrl;
  assign bus.alu_srca_sel = ctl.alu_srca_sel;
  assign bus.alu_srcb_sel = ctl.alu_srcb_sel;
  assign bus.imm_zext     = ctl.imm_zext;
  assign bus.iord         = ctl.iord;
  assign bus.mem_read     = ctl.mem_read;
  assign bus.mem_write    = ctl.mem_write;
  assign bus.ir_write     = ctl.ir_write;
  assign bus.pc_write     = ctl.pc_write;
  assign bus.pc_src       = ctl.pc_src;
  assign bus.reg_write    = ctl.reg_write;
  assign bus.reg_dst      = ctl.reg_dst;
  assign bus.mem_to_reg   = ctl.mem_to_reg;
  assign bus.exc          = ctl.exc;

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: each instruction is expanded into the cycle-by-cycle script the sequencer
// must follow (inputs to apply, outputs expected), then replayed against the DUT.
module tb_mc_ctrl;
  localparam int TO = 15;

  localparam logic [2:0] KI = 3'd0, KA = 3'd1, KL = 3'd2, KS = 3'd3,
                         KBEQ = 3'd4, KBNE = 3'd5, KJ = 3'd6;

  typedef struct packed {
    logic [3:0] st;
    logic [3:0] alu;
    logic       srca;
    logic [1:0] srcb;
    logic       zext;
    logic       iord;
    logic       mr;
    logic       mw;
    logic       irw;
    logic       pcw;
    logic [1:0] pcs;
    logic       rw;
    logic       rdst;
    logic       m2r;
    logic       exc;
  } obs_t;

  typedef struct {
    obs_t o;
    logic rdy;
    logic zero;
    logic ovf;
  } step_t;

  typedef struct packed {
    logic [2:0] kind;
    logic [3:0] alu;
    logic [1:0] srcb;
    logic       zext;
    logic       rty;
    logic       ovc;
  } dec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  obs_t exp_o;
  logic exp_vld = 1'b0;
  logic [31:0] cur_ins = 32'h0;
  step_t script[$];

  mc_ctrl_if ifc ();
  mc_ctrl #(.MEM_TIMEOUT(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc.master));

  always #5 clk = ~clk;

  // Compare process: every cycle carrying an expectation is checked mid-low-phase.
  always @(negedge clk) begin
    obs_t got;
    #2;
    got = {ifc.state, ifc.alu_ctrl, ifc.alu_srca_sel, ifc.alu_srcb_sel, ifc.imm_zext,
           ifc.iord, ifc.mem_read, ifc.mem_write, ifc.ir_write, ifc.pc_write, ifc.pc_src,
           ifc.reg_write, ifc.reg_dst, ifc.mem_to_reg, ifc.exc};
    if (exp_vld) begin
      checks++;
      if (got !== exp_o) begin
        errors++;
        $display("FAIL cycle t=%0t instr=%h: state got=%0d want=%0d, outputs got=%h want=%h",
                 $time, cur_ins, got.st, exp_o.st, got, exp_o);
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  function automatic dec_t decode(input logic [31:0] w);
    dec_t d;
    d = '0;
    d.kind = KI;
    case (w[31:26])
      6'h00: begin
        d.kind = KA; d.rty = 1'b1;
        case (w[5:0])
          6'h20: begin d.alu = 4'b0010; d.ovc = 1'b1; end
          6'h21: d.alu = 4'b0011;
          6'h22: begin d.alu = 4'b0100; d.ovc = 1'b1; end
          6'h23: d.alu = 4'b0101;
          6'h24: d.alu = 4'b0000;
          6'h25: d.alu = 4'b0001;
          6'h26: d.alu = 4'b1110;
          6'h27: d.alu = 4'b1111;
          6'h2A: d.alu = 4'b0110;
          6'h2B: d.alu = 4'b0111;
          6'h00: d.alu = 4'b1000;
          6'h02: d.alu = 4'b1001;
          6'h04: d.alu = 4'b1010;
          6'h06: d.alu = 4'b1011;
          default: d.kind = KI;
        endcase
      end
      6'h08: begin d.kind = KA; d.alu = 4'b0010; d.srcb = 2; d.ovc = 1'b1; end
      6'h09: begin d.kind = KA; d.alu = 4'b0011; d.srcb = 2; end
      6'h0A: begin d.kind = KA; d.alu = 4'b0110; d.srcb = 2; end
      6'h0B: begin d.kind = KA; d.alu = 4'b0111; d.srcb = 2; end
      6'h0C: begin d.kind = KA; d.alu = 4'b0000; d.srcb = 2; d.zext = 1'b1; end
      6'h0D: begin d.kind = KA; d.alu = 4'b0001; d.srcb = 2; d.zext = 1'b1; end
      6'h0E: begin d.kind = KA; d.alu = 4'b1110; d.srcb = 2; d.zext = 1'b1; end
      6'h0F: begin d.kind = KA; d.alu = 4'b1100; d.srcb = 2; end
      6'h23: begin d.kind = KL; d.alu = 4'b0010; d.srcb = 2; end
      6'h2B: begin d.kind = KS; d.alu = 4'b0010; d.srcb = 2; end
      6'h04: d.kind = KBEQ;
      6'h05: d.kind = KBNE;
      6'h02: d.kind = KJ;
      default: d.kind = KI;
    endcase
    return d;
  endfunction

  function automatic obs_t blank(input logic [3:0] st);
    obs_t o;
    o = '0;
    o.st = st;
    return o;
  endfunction

  function automatic void push(input obs_t o, input logic rdy, input logic z, input logic v);
    step_t s;
    s.o = o; s.rdy = rdy; s.zero = z; s.ovf = v;
    script.push_back(s);
  endfunction

  function automatic void push_exc();
    obs_t o;
    o = blank(4'd11);
    o.exc = 1'b1; o.pcw = 1'b1; o.pcs = 2'd3;
    push(o, 1'($urandom), 1'($urandom), 1'($urandom));
  endfunction

  // w stalls then ready; returns 1 when the stall budget runs out first.
  function automatic bit mem_wait(input obs_t o, input int w, input bit fetch);
    for (int i = 0; i < TO; i++) begin
      if (i == w) begin
        obs_t r;
        r = o;
        r.irw = fetch;
        push(r, 1'b1, 1'($urandom), 1'($urandom));
        return 1'b0;
      end
      push(o, 1'b0, 1'($urandom), 1'($urandom));
    end
    return 1'b1;
  endfunction

  function automatic void build(input logic [31:0] ins, input int wf, input int wm,
                                input logic z, input logic v);
    dec_t d;
    obs_t o;
    d = decode(ins);
    script.delete();
    o = blank(4'd0); o.mr = 1'b1; o.srcb = 2'd1; o.alu = 4'b0011;
    if (mem_wait(o, wf, 1'b1)) begin push_exc(); return; end
    o = blank(4'd1); o.pcw = 1'b1;
    push(o, 1'($urandom), 1'($urandom), 1'($urandom));
    case (d.kind)
      KJ: begin
        o = blank(4'd10); o.pcw = 1'b1; o.pcs = 2'd2;
        push(o, 1'($urandom), 1'($urandom), 1'($urandom));
      end
      KBEQ, KBNE: begin
        o = blank(4'd7); o.srca = 1'b1; o.alu = 4'b0100;
        push(o, 1'($urandom), 1'($urandom), 1'($urandom));
        o = blank(4'd8); o.srcb = 2'd3; o.alu = 4'b0011;
        push(o, 1'($urandom), z, 1'($urandom));
        o = blank(4'd9); o.pcw = (d.kind == KBEQ) ? z : !z;
        push(o, 1'($urandom), 1'($urandom), 1'($urandom));
      end
      KA, KL, KS: begin
        o = blank(4'd2); o.srca = 1'b1; o.srcb = d.srcb; o.alu = d.alu; o.zext = d.zext;
        push(o, 1'($urandom), 1'($urandom), 1'($urandom));
        if (d.kind == KA) begin
          o = blank(4'd3); o.rdst = d.rty; o.rw = !(d.ovc && v);
          push(o, 1'($urandom), 1'($urandom), v);
          if (d.ovc && v) push_exc();
        end else if (d.kind == KL) begin
          o = blank(4'd4); o.iord = 1'b1; o.mr = 1'b1;
          if (mem_wait(o, wm, 1'b0)) push_exc();
          else begin
            o = blank(4'd5); o.rw = 1'b1; o.m2r = 1'b1;
            push(o, 1'($urandom), 1'($urandom), 1'($urandom));
          end
        end else begin
          o = blank(4'd6); o.iord = 1'b1; o.mw = 1'b1;
          if (mem_wait(o, wm, 1'b0)) push_exc();
        end
      end
      default: push_exc();
    endcase
  endfunction

  task automatic drive(input step_t s);
    @(negedge clk);
    rst_n = 1'b1;
    ifc.instr = cur_ins;
    ifc.mem_ready = s.rdy;
    ifc.alu_zero = s.zero;
    ifc.alu_overflow = s.ovf;
    exp_o = s.o;
    exp_vld = 1'b1;
  endtask

  task automatic drive_rst(input int n, input logic rdy);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst_n = 1'b0;
      ifc.mem_ready = rdy;
      ifc.alu_zero = 1'($urandom);
      ifc.alu_overflow = 1'($urandom);
      exp_o = blank(4'd0);
      exp_vld = 1'b1;
    end
  endtask

  task automatic run_steps(input int n);
    for (int i = 0; i < n && script.size() > 0; i++) drive(script.pop_front());
  endtask

  task automatic prep(input logic [31:0] ins, input int wf, input int wm,
                      input logic z, input logic v);
    cur_ins = ins;
    build(ins, wf, wm, z, v);
  endtask

  function automatic int count_rw_rd();
    int n = 0;
    foreach (script[i]) if (script[i].o.rw && script[i].o.rdst) n++;
    return n;
  endfunction

  function automatic int count_rw();
    int n = 0;
    foreach (script[i]) if (script[i].o.rw) n++;
    return n;
  endfunction

  function automatic int count_mrd();
    int n = 0;
    foreach (script[i]) if (script[i].o.st == 4'd4 && script[i].o.mr && script[i].o.iord) n++;
    return n;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [5:0] rfun [14] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                              6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h04, 6'h06};
    logic [5:0] iops [8]  = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
    logic [5:0] bad_op [5] = '{6'h3F, 6'h01, 6'h20, 6'h10, 6'h03};
    logic [5:0] bad_fn [3] = '{6'h3F, 6'h08, 6'h01};
    logic [31:0] w;
    int k;
    w = $urandom;
    k = $urandom_range(0, 28);
    if (k < 14)       begin w[31:26] = 6'h00; w[5:0] = rfun[k]; end
    else if (k < 22)  w[31:26] = iops[k-14];
    else if (k == 22) w[31:26] = 6'h23;
    else if (k == 23) w[31:26] = 6'h2B;
    else if (k == 24) w[31:26] = 6'h04;
    else if (k == 25) w[31:26] = 6'h05;
    else if (k == 26) w[31:26] = 6'h02;
    else if (k == 27) w[31:26] = bad_op[$urandom_range(0, 4)];
    else begin w[31:26] = 6'h00; w[5:0] = bad_fn[$urandom_range(0, 2)]; end
    return w;
  endfunction

  function automatic int rand_wait();
    int r = $urandom_range(0, 19);
    if (r < 10) return 0;
    if (r < 16) return $urandom_range(1, 4);
    if (r == 16) return TO - 2;
    if (r == 17) return TO - 1;
    if (r == 18) return TO;
    return $urandom_range(TO + 1, TO + 5);
  endfunction

  initial begin
    ifc.instr = 32'h0; ifc.mem_ready = 1'b0; ifc.alu_zero = 1'b0; ifc.alu_overflow = 1'b0;
    drive_rst(3, 1'b1);

    // addu $3,$1,$2 with zero wait states
    prep(32'h00221821, 0, 0, 1'b0, 1'b0);
    check("addu_len", script.size(), 4);
    check("addu_states", int'({script[0].o.st, script[1].o.st, script[2].o.st, script[3].o.st}), 16'h0123);
    check("addu_exec_alu", int'(script[2].o.alu), 3);
    check("addu_rw_rd_cycles", count_rw_rd(), 1);
    run_steps(100);

    // lw with three stall cycles
    prep(32'h8C220004, 0, 3, 1'b0, 1'b0);
    check("lw_len", script.size(), 8);
    check("lw_memrd_cycles", count_mrd(), 4);
    run_steps(100);

    prep(32'h10220003, 0, 0, 1'b1, 1'b0);
    check("beq_taken_pcw", int'(script[script.size()-1].o.pcw), 1);
    run_steps(100);
    prep(32'h14220003, 0, 0, 1'b1, 1'b0);
    check("bne_eq_pcw", int'(script[script.size()-1].o.pcw), 0);
    run_steps(100);

    prep(32'h08000010, 0, 0, 1'b0, 1'b0);
    check("j_len", script.size(), 3);
    run_steps(100);

    // add overflow
    prep(32'h00221820, 0, 0, 1'b0, 1'b1);
    check("add_ovf_rw", count_rw(), 0);
    check("add_ovf_last_state", int'(script[script.size()-1].o.st), 11);
    run_steps(100);

    prep(32'hFC000000, 0, 0, 1'b0, 1'b0);
    check("illegal_op_len", script.size(), 3);
    run_steps(100);
    prep(32'h0000003F, 0, 0, 1'b0, 1'b0);
    run_steps(100);

    // fetch stall boundaries: ready on the last allowed cycle, then a full timeout
    prep(32'h00221821, TO - 1, 0, 1'b0, 1'b0);
    run_steps(100);
    prep(32'h00221821, TO + 3, 0, 1'b0, 1'b0);
    check("fetch_timeout_len", script.size(), TO + 1);
    run_steps(100);

    // reset while a store is stalled
    prep(32'hAC220004, 0, 10, 1'b0, 1'b0);
    run_steps(5);
    script.delete();
    drive_rst(2, 1'b1);
    prep(32'h00221821, 0, 0, 1'b0, 1'b0);
    run_steps(100);

    for (int n = 0; n < 300; n++) begin
      prep(rand_instr(), rand_wait(), rand_wait(), 1'($urandom), 1'($urandom));
      run_steps(100);
    end

    @(negedge clk);
    exp_vld = 1'b0;
    #5;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multicycle sequencer for the MIPS core.
- Decodes the instruction register and steps the shared registered ALU (4-bit op code, result valid one cycle after operands) through fetch, decode, execute, memory and writeback.
- Drives all datapath muxes, write enables and memory strobes.
- Handles memory wait states, arithmetic overflow, illegal opcodes and memory timeout by raising an exception and redirecting the PC.

Parameters:
- MEM_TIMEOUT, 15: max cycles waiting for mem_ready before exception; 1..255.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  synchronous active-low reset.
- instr  in  32  current IR contents.
- mem_ready  in  1  memory access complete this cycle.
- alu_zero  in  1  ALU Zero flag (reflects last latched result).
- alu_overflow  in  1  ALU Overflow flag (reflects last latched result).
- alu_ctrl  out  4  ALU op code.
- alu_srca_sel  out  1  0=PC, 1=regA.
- alu_srcb_sel  out  2  0=regB, 1=const 4, 2=ext imm, 3=sign-ext imm<<2.
- imm_zext  out  1  1=zero-extend imm16, 0=sign-extend.
- iord  out  1  memory address: 0=PC, 1=ALU result.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  load IR.
- pc_write  out  1  load PC.
- pc_src  out  2  0=ALU result, 2=jump target, 3=exception vector.
- reg_write  out  1  register file write.
- reg_dst  out  1  0=rt, 1=rd.
- mem_to_reg  out  1  0=ALU result, 1=memory data.
- exc  out  1  one-cycle exception pulse.
- state  out  4  current state, debug.

Behaviour:
- Reset: while rst_n=0 at a clock edge, state<=FETCH and timeout counter<=0.
  - All strobes (mem_read, mem_write, ir_write, pc_write, reg_write, exc) are forced 0 while rst_n is low.
  - All other outputs are 0 during reset.
  - Reset mid-access aborts the access; no write strobe may assert in the reset cycle.
- Outputs are Moore, decoded from state plus instr; no output depends combinationally on mem_ready except ir_write and the state transition.
- ALU op codes: and 0000, or 0001, add 0010, addu 0011, sub 0100, subu 0101, slt 0110, sltu 0111, sll 1000, srl 1001, sllv 1010, srlv 1011, lui 1100, xor 1110, nor 1111.
- Decode:
  - R-type (op 000000), funct: 100000 add, 100001 addu, 100010 sub, 100011 subu, 100100 and, 100101 or, 100110 xor, 100111 nor, 101010 slt, 101011 sltu, 000000 sll, 000010 srl, 000100 sllv, 000110 srlv.
  - I-type: addi 001000 (add), addiu 001001 (addu), slti 001010, sltiu 001011, andi/ori/xori 001100/001101/001110 (imm_zext=1), lui 001111.
  - Memory and control: lw 100011, sw 101011, beq 000100, bne 000101, j 000010.
  - Any other op or funct is illegal and goes to EXC.
- FETCH: iord=0, mem_read=1, srca=PC, srcb=4, alu_ctrl=addu.
  - Stays in FETCH until mem_ready; in the mem_ready cycle ir_write=1, then DECODE.
- DECODE: pc_write=1, pc_src=0 (ALU result now holds PC+4). Next state by opcode:
  - R/I ALU ops -> EXEC.
  - lw/sw -> EXEC with add and sign-ext imm.
  - beq/bne -> BR_CMP.
  - j -> JUMP.
  - illegal -> EXC.
- EXEC: srca=regA, srcb per instruction, alu_ctrl per decode.
  - Next state: WB_ALU for ALU ops, MEM_RD for lw, MEM_WR for sw.
- WB_ALU: reg_write=1, reg_dst=1 for R-type, mem_to_reg=0.
  - For add/addi/sub only: if alu_overflow=1, reg_write=0 and next state is EXC.
  - Otherwise next state is FETCH.
- MEM_RD: iord=1, mem_read=1; wait for mem_ready, then WB_MEM.
- WB_MEM: reg_write=1, reg_dst=0, mem_to_reg=1, then FETCH.
- MEM_WR: iord=1, mem_write=1 held until mem_ready, then FETCH.
- BR_CMP: srca=regA, srcb=regB, alu_ctrl=sub.
- BR_TGT: srca=PC, srcb=3, alu_ctrl=addu; capture alu_zero into internal eq flag.
- BR_TAKE: pc_write=1, pc_src=0 iff (beq and eq) or (bne and !eq); then FETCH.
- JUMP: pc_write=1, pc_src=2; then FETCH.
- EXC: exc=1, pc_write=1, pc_src=3, all other strobes 0; then FETCH.
- Timeout:
  - Counter clears on entry to FETCH, MEM_RD and MEM_WR, and increments each cycle without mem_ready.
  - Reaching MEM_TIMEOUT with mem_ready still 0 -> EXC next cycle, with no ir_write or reg_write.
  - mem_ready on the same cycle as the limit is honoured as a normal completion.
- Minimum latencies (zero wait states):
  - R/I ALU ops and sw: 4 cycles.
  - lw and branches: 5 cycles.
  - j: 3 cycles.
  - exception entry: +1 cycle.
- state encoding: FETCH 0, DECODE 1, EXEC 2, WB_ALU 3, MEM_RD 4, WB_MEM 5, MEM_WR 6, BR_CMP 7, BR_TGT 8, BR_TAKE 9, JUMP 10, EXC 11.

Test Plan:
- addu $3,$1,$2 (0x00221821), mem_ready always 1:
  - required states 0,1,2,3,0.
  - alu_ctrl=0011 in EXEC; reg_write=1 with reg_dst=1 exactly one cycle.
- lw with mem_ready delayed 3 cycles in MEM_RD:
  - mem_read and iord held for 4 cycles.
  - WB_MEM asserts reg_write with mem_to_reg=1, then FETCH.
- beq with alu_zero=1 captured in BR_TGT:
  - pc_write=1, pc_src=0 in BR_TAKE.
  - same stimulus as bne gives pc_write=0 in BR_TAKE.
- add with alu_overflow=1 in WB_ALU:
  - reg_write stays 0.
  - next cycle exc=1, pc_src=3, pc_write=1, then FETCH.
- Illegal op 0x3F or funct 0x3F, and mem_ready never asserted in FETCH with MEM_TIMEOUT=15:
  - both cases produce exc pulse; the timeout fires after 15 waiting cycles.
- rst_n low during MEM_WR:
  - mem_write=0 in the reset cycle; state=0 after the edge.
  - no strobes until rst_n=1, then a fetch resumes.
